// File: rtl/sparc_exu_ecl_llscbd.sv
// ---------------------------------------------------------------------------
// sparc_exu_ecl_llscbd
//
// Long-latency result scoreboard for the EXU execution control logic.
// Holds up to NUM_ENT outstanding long-latency destinations (load misses,
// divides), each tagged with its thread. Issuing instructions compare their
// source registers against every pending entry and stall on a hit. When a
// result returns, the entry's rd/tid is read out for the writeback address
// and the entry is freed.
//
// Ports:
//   rclk, reset          clock, synchronous active-high reset
//   alloc_vld/tid/rd     allocate an entry for a long-latency op
//   alloc_tag            lowest free entry index (from current state)
//   full                 every entry valid
//   ret_vld/ret_tag      result return, frees entry ret_tag
//   ret_rd/ret_tid       rd/tid held in entry ret_tag (combinational read)
//   flush_vld/flush_tid  kill all pending entries of one thread
//   chk_tid, chk_rs1..3, chk_rs1..3_vld
//                        sources of the instruction being checked
//   stall                a used source hits a pending entry
//   occ_cnt              number of valid entries (registered)
//   err                  one-cycle protocol error pulse (registered)
// ---------------------------------------------------------------------------
module sparc_exu_ecl_llscbd #(
  parameter int NUM_ENT = 4,
  parameter int TAG_W   = 2
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             alloc_vld,
  input  logic [1:0]       alloc_tid,
  input  logic [6:0]       alloc_rd,
  output logic [TAG_W-1:0] alloc_tag,
  output logic             full,
  input  logic             ret_vld,
  input  logic [TAG_W-1:0] ret_tag,
  output logic [6:0]       ret_rd,
  output logic [1:0]       ret_tid,
  input  logic             flush_vld,
  input  logic [1:0]       flush_tid,
  input  logic [1:0]       chk_tid,
  input  logic [6:0]       chk_rs1,
  input  logic [6:0]       chk_rs2,
  input  logic [6:0]       chk_rs3,
  input  logic             chk_rs1_vld,
  input  logic             chk_rs2_vld,
  input  logic             chk_rs3_vld,
  output logic             stall,
  output logic [TAG_W:0]   occ_cnt,
  output logic             err
);

  // Entry state
  logic [NUM_ENT-1:0] vld_q;
  logic [NUM_ENT-1:0] vld_nxt;
  logic [1:0]         tid_q [NUM_ENT];
  logic [6:0]         rd_q  [NUM_ENT];

  // Per-entry event decodes
  logic [NUM_ENT-1:0] ret_hit;
  logic [NUM_ENT-1:0] flush_hit;

  logic alloc_flush_drop;
  logic alloc_ok;
  logic err_nxt;

  // 7-bit register equality: XOR then NOR-reduce.
  function automatic logic reg_eq(input logic [6:0] a, input logic [6:0] b);
    return ~|(a ^ b);
  endfunction

  function automatic logic [TAG_W:0] popcount(input logic [NUM_ENT-1:0] v);
    logic [TAG_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_ENT; i++) cnt = cnt + (TAG_W+1)'(v[i]);
    return cnt;
  endfunction

  // Lowest-index free entry; scanning downward leaves the lowest one last.
  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    alloc_tag = '0;
    for (int e = NUM_ENT - 1; e >= 0; e--) begin
      if (!vld_q[e]) alloc_tag = TAG_W'(e);
    end
  end

  assign full = &vld_q;

  // An alloc for the thread being flushed belongs to a killed instruction
  // stream, so it is dropped quietly even if the scoreboard is full.
  assign alloc_flush_drop = flush_vld & (alloc_tid == flush_tid);
  assign alloc_ok         = alloc_vld & ~full & ~alloc_flush_drop;

  always_comb begin
    ret_hit   = '0;
    flush_hit = '0;
    vld_nxt   = '0;
    for (int e = 0; e < NUM_ENT; e++) begin
      ret_hit[e]   = ret_vld & (ret_tag == TAG_W'(e));
      flush_hit[e] = flush_vld & (tid_q[e] == flush_tid);
      // alloc_tag always points at an entry that is currently free, so the
      // freshly returned entry is never re-used in the same cycle.
      vld_nxt[e]   = (vld_q[e] & ~ret_hit[e] & ~flush_hit[e])
                   | (alloc_ok & (alloc_tag == TAG_W'(e)));
    end
  end

  assign err_nxt = (alloc_vld & full & ~alloc_flush_drop)
                 | (ret_vld & ~vld_q[ret_tag] & ~flush_hit[ret_tag]);

  // Writeback address for the returning result.
  assign ret_rd  = rd_q[ret_tag];
  assign ret_tid = tid_q[ret_tag];

  // Dependency check. The returning entry is excluded because its result is
  // on the bypass path this cycle; %g0 never creates a dependency.
  always_comb begin
    stall = 1'b0;
    for (int e = 0; e < NUM_ENT; e++) begin
      if (vld_q[e] && !ret_hit[e] && (tid_q[e] == chk_tid)) begin
        if (chk_rs1_vld && (chk_rs1 != 7'd0) && reg_eq(rd_q[e], chk_rs1)) stall = 1'b1;
        if (chk_rs2_vld && (chk_rs2 != 7'd0) && reg_eq(rd_q[e], chk_rs2)) stall = 1'b1;
        if (chk_rs3_vld && (chk_rs3 != 7'd0) && reg_eq(rd_q[e], chk_rs3)) stall = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge rclk) begin
    if (reset) begin
      vld_q   <= '0;
      occ_cnt <= '0;
      err     <= 1'b0;
    end else begin
      vld_q   <= vld_nxt;
      occ_cnt <= popcount(vld_nxt);
      err     <= err_nxt;
    end
  end

  // NOTE: the rd/tid payload is deliberately not reset; it is only ever
  // observed qualified by vld, so reset logic on it would buy nothing.
  always_ff @(posedge rclk) begin
    if (alloc_ok && !reset) begin
      tid_q[alloc_tag] <= alloc_tid;
      rd_q[alloc_tag]  <= alloc_rd;
    end
  end

endmodule
